// File: rtl/fetch_stage.sv
// Instruction fetch stage: program counter, ROM addressing and IF/ID pipeline register.
// Optional saturating stall/flush counters are built only when FETCH_PERF_CNT_EN is defined.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 freeze,
  input  logic                 branch_taken,
  input  logic [31:0]          branch_addr,
  output logic [31:0]          inst_addr,
  input  logic [31:0]          inst_data,
  output logic [31:0]          if_id_pc,
  output logic [31:0]          if_id_inst,
  output logic                 if_id_valid,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_inst_q, ifid_inst_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  // Branch beats freeze: a stalled IF/ID entry is on the wrong path and is dropped.
  always_comb begin
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_inst_d  = ifid_inst_q;
    ifid_valid_d = ifid_valid_q;
    if (branch_taken) begin
      pc_d         = branch_addr;
      ifid_pc_d    = 32'd0;
      ifid_inst_d  = 32'd0;
      ifid_valid_d = 1'b0;
    end else if (!freeze) begin
      pc_d         = pc_plus4;
      ifid_pc_d    = pc_plus4;
      ifid_inst_d  = inst_data;
      ifid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      ifid_pc_q    <= 32'd0;
      ifid_inst_q  <= 32'd0;
      ifid_valid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_inst_q  <= ifid_inst_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign inst_addr   = pc_q;
  assign if_id_pc    = ifid_pc_q;
  assign if_id_inst  = ifid_inst_q;
  assign if_id_valid = ifid_valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] stall_q, stall_d;
  logic [CNT_WIDTH-1:0] flush_q, flush_d;

  // Counters saturate at all-ones rather than wrapping.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (branch_taken) begin
      if (flush_q != '1) flush_d = flush_q + 1'b1;
    end else if (freeze) begin
      if (stall_q != '1) stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the five-stage ARM pipeline. The block holds the program counter and addresses the instruction ROM. It latches the fetched word and PC+4 into the IF/ID register, which feeds the ID stage. It obeys `freeze`, driven by the hazard-detection unit's `hazard_detected`, and `branch_taken` from EXE. Optional saturating performance counters record stall and flush cycles.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: PC value after reset.
- `CNT_WIDTH`, 16: width of the performance counters.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `freeze`, input, 1: stall request from hazard detection; holds the PC and IF/ID.
- `branch_taken`, input, 1: EXE-stage branch resolution; redirects the PC and flushes IF/ID.
- `branch_addr`, input, 32: branch target, valid while `branch_taken` is 1.
- `inst_addr`, output, 32: instruction ROM address, combinational equal to PC.
- `inst_data`, input, 32: ROM read data, combinational from `inst_addr` in the same cycle.
- `if_id_pc`, output, 32: registered PC+4 of the held instruction.
- `if_id_inst`, output, 32: registered instruction word.
- `if_id_valid`, output, 1: 1 means IF/ID holds a real instruction; 0 means a bubble.
- `stall_cnt`, output, CNT_WIDTH: freeze-cycle counter.
- `flush_cnt`, output, CNT_WIDTH: branch-flush counter.

## Operation
- **Reset:** `rst`=1 asynchronously forces:
  - PC = `RESET_PC`
  - `if_id_pc` = 0, `if_id_inst` = 0, `if_id_valid` = 0
  - `stall_cnt` = 0, `flush_cnt` = 0
- **PC update**, priority high to low:
  - `branch_taken`=1: PC <= `branch_addr`. Branch overrides freeze.
  - `freeze`=1: PC holds.
  - Otherwise: PC <= PC+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0). No carry out.
- **IF/ID update**, same priority:
  - `branch_taken`=1 (flush): pc <= 0, inst <= 0, valid <= 0.
  - `freeze`=1: all three hold their values.
  - Otherwise: pc <= PC+4, inst <= `inst_data`, valid <= 1.
- **Bubbles:** ID treats `if_id_valid`=0 as a NOP. A zero word is not a safe NOP in ARM (ANDEQ), so valid must be honoured.
- **Simultaneous `freeze` and `branch_taken`:** the branch wins. The stalled instruction in IF/ID is on the wrong path and is discarded.
- **Combinational path:** `inst_addr` is never registered; the ROM path is combinational within the cycle.

## Timing
- Fetch-to-IF/ID latency is 1 cycle. The word at PC in cycle n appears on `if_id_inst` in cycle n+1.
- The branch penalty at this stage is 1 flushed slot. The target word is in IF/ID 2 edges after the `branch_taken` cycle.
- `freeze` is sampled at the edge it is asserted before. A one-cycle freeze repeats exactly one IF/ID value.
- Reset released mid-cycle: the first fetch is `RESET_PC` at the next edge, and `if_id_valid` rises on the first edge after release.
- Counters update on the same edge as the PC.

## Configuration
- Macro `FETCH_PERF_CNT_EN`.
- **Defined:**
  - `stall_cnt` increments each edge with `freeze`=1 and `branch_taken`=0.
  - `flush_cnt` increments each edge with `branch_taken`=1.
  - Both saturate at all-ones and never wrap.
  - Both clear only on `rst`.
- **Undefined:** both ports exist but are tied to 0, and no counter flops are built. Fetch behaviour is identical in both builds.

## Test plan
- **Reset and sequential fetch:** hold `rst`=1, then release, with `inst_data`=addr^32'hE000_0000. Required: `inst_addr` steps 0, 4, 8. On the edge after fetch of 8, `if_id_pc`=12, `if_id_inst`=32'hE000_0008, `if_id_valid`=1.
- **Freeze:** assert `freeze` 2 cycles while PC=16. Required: `inst_addr` stays 16 for 3 cycles. IF/ID holds pc=16 and its instruction for 2 extra cycles. `stall_cnt`=2 when the macro is defined.
- **Branch flush:** PC=20, `branch_taken`=1, `branch_addr`=32'h100. Required: next cycle `inst_addr`=32'h100 and `if_id_valid`=0. The following edge gives `if_id_pc`=32'h104 and valid=1. `flush_cnt`=1.
- **Freeze plus branch same cycle:** `freeze`=1 and `branch_taken`=1 with `branch_addr`=32'h40. Required: PC=32'h40, IF/ID flushed, `stall_cnt` unchanged.
- **Wrap:** `RESET_PC`=32'hFFFF_FFFC. Required: second fetch address 0, and `if_id_pc`=0 for the first instruction.
- **Saturation and asynchronous reset:** `CNT_WIDTH`=2, freeze 5 cycles. Required: `stall_cnt` sticks at 3. Then pulse `rst` between edges. Required: all outputs are at their reset values before the next edge.
